// File: rtl/pll_dyn_pkg.sv
// Shared types and helpers for the GW5A PLL dynamic-divider sequencer.
// Divider encodings and set legality live here so every user agrees on them.
package pll_dyn_pkg;

  localparam int W6 = 6;
  localparam int W7 = 7;
  localparam int GATE_CYC = 2;

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_WAIT_LOCK,
    S_LOCK_FILT,
    S_RUN,
    S_GATE,
    S_APPLY,
    S_FAIL
  } state_e;

  function automatic logic [W6-1:0] enc6(input logic [W6-1:0] d);
    logic [W6:0] t;
    t = 7'd64 - {1'b0, d};
    return t[W6-1:0];
  endfunction

  function automatic logic [W7-1:0] enc7(input logic [W7-1:0] d);
    logic [W7:0] t;
    t = 8'd128 - {1'b0, d};
    return t[W7-1:0];
  endfunction

  // 6-bit fields cannot exceed 64, so only zero dividers are rejectable
  function automatic logic cfg_legal(
    input logic [W6-1:0] idiv,
    input logic [W6-1:0] fbdiv,
    input logic [W7-1:0] mdiv,
    input logic          odiv_zero
  );
    return (idiv != '0) && (fbdiv != '0) && (mdiv != '0) && !odiv_zero;
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_lock_filter.sv
// Lock synchroniser and consecutive-high filter for the PLL sequencer.
// done_o fires once lock has been seen high LOCK_FILT cycles in a row.
module pll_lock_filter #(
  parameter int LOCK_FILT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  input  logic en_i,
  output logic lock_s_o,
  output logic done_o
);

  localparam int CW = $clog2(LOCK_FILT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign lock_s_o = sync_q[1];
  assign done_o   = en_i && lock_s_o
                 && (cnt_q >= CW'(LOCK_FILT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || !lock_s_o)
      cnt_d = '0;
    else if (cnt_q != CW'(LOCK_FILT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], lock_i};
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Runtime divider sequencer for the GW5A PLL: gate, apply, reset, relock.
// Define PLL_AUTO_RELOCK_EN to retry automatically on lock loss in RUN.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int NUM_OUT      = 1,
  parameter int DEF_IDIV     = 1,
  parameter int DEF_FBDIV    = 1,
  parameter int DEF_MDIV     = 32,
  parameter logic [NUM_OUT*7-1:0] DEF_ODIV = {NUM_OUT{7'd8}},
  parameter int RST_HOLD     = 32,
  parameter int LOCK_FILT    = 256,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [5:0]           cfg_idiv,
  input  logic [5:0]           cfg_fbdiv,
  input  logic [6:0]           cfg_mdiv,
  input  logic [NUM_OUT*7-1:0] cfg_odiv,
  input  logic                 pll_lock,
  output logic                 pll_reset,
  output logic [5:0]           pll_idsel,
  output logic [5:0]           pll_fbdsel,
  output logic [6:0]           pll_mdsel,
  output logic [NUM_OUT*7-1:0] pll_odsel,
  output logic [NUM_OUT-1:0]   pll_enclk,
  output logic                 locked,
  output logic                 busy,
  output logic                 err_cfg,
  output logic                 err_fail
);

  localparam int HOLD_MAX = (RST_HOLD > GATE_CYC) ? RST_HOLD : GATE_CYC;
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [5:0] idiv_q, idiv_d, fbdiv_q, fbdiv_d;
  logic [6:0] mdiv_q, mdiv_d;
  logic [NUM_OUT*7-1:0] odiv_q, odiv_d;
  logic err_cfg_q, err_cfg_d;
  logic odz, legal, lock_s, filt_done, filt_en;

  pll_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_filt (
    .clk_i   (clkin),
    .rst_i   (reset),
    .lock_i  (pll_lock),
    .en_i    (filt_en),
    .lock_s_o(lock_s),
    .done_o  (filt_done)
  );

  assign filt_en = (state_q == S_WAIT_LOCK) || (state_q == S_LOCK_FILT);
  assign legal   = cfg_legal(cfg_idiv, cfg_fbdiv, cfg_mdiv, odz);
  assign retry_inc = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;
  assign err_cfg  = err_cfg_q;
  assign err_fail = (state_q == S_FAIL);

  always_comb begin
    odz = 1'b0;
    for (int i = 0; i < NUM_OUT; i++)
      if (cfg_odiv[i*7 +: 7] == '0) odz = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    idiv_d    = idiv_q;
    fbdiv_d   = fbdiv_q;
    mdiv_d    = mdiv_q;
    odiv_d    = odiv_q;
    err_cfg_d = 1'b0;
    cfg_ready = 1'b0;
    locked    = 1'b0;
    busy      = 1'b1;
    pll_reset = 1'b0;
    pll_enclk = '0;
    unique case (state_q)
      S_RST_HOLD: begin
        pll_reset = 1'b1;
        if (cnt_q >= CW'(RST_HOLD - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_LOCK_FILT;
        end else if (to_q >= TW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RW'(MAX_RETRY)) ? S_FAIL : S_RST_HOLD;
        end
      end
      S_LOCK_FILT: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (filt_done) begin
          retry_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        locked    = lock_s;
        pll_enclk = {NUM_OUT{lock_s}};
        // A pending set outranks a lock fall in the same cycle
        if (cfg_valid) begin
          if (legal) begin
            idiv_d  = cfg_idiv;
            fbdiv_d = cfg_fbdiv;
            mdiv_d  = cfg_mdiv;
            odiv_d  = cfg_odiv;
            state_d = S_GATE;
          end else begin
            err_cfg_d = 1'b1;
          end
        end else if (!lock_s) begin
`ifdef PLL_AUTO_RELOCK_EN
          retry_d = retry_inc;
          state_d = (retry_inc == RW'(MAX_RETRY)) ? S_FAIL : S_RST_HOLD;
`else
          state_d = S_FAIL;
`endif
        end
      end
      S_GATE: begin
        if (cnt_q >= CW'(GATE_CYC - 1)) state_d = S_APPLY;
      end
      S_APPLY: state_d = S_RST_HOLD;
      S_FAIL: begin
        pll_reset = 1'b1;
        busy      = 1'b0;
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (legal) begin
            idiv_d  = cfg_idiv;
            fbdiv_d = cfg_fbdiv;
            mdiv_d  = cfg_mdiv;
            odiv_d  = cfg_odiv;
            retry_d = '0;
            state_d = S_GATE;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      default: state_d = S_RST_HOLD;
    endcase
  end

  always_comb begin
    if (state_d != state_q)
      cnt_d = '0;
    else
      cnt_d = (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
    to_d = to_q;
    if (state_q == S_RST_HOLD)
      to_d = '0;
    else if (filt_en && to_q != TW'(LOCK_TIMEOUT))
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q    <= S_RST_HOLD;
      cnt_q      <= '0;
      to_q       <= '0;
      retry_q    <= '0;
      err_cfg_q  <= 1'b0;
      idiv_q     <= 6'(DEF_IDIV);
      fbdiv_q    <= 6'(DEF_FBDIV);
      mdiv_q     <= 7'(DEF_MDIV);
      odiv_q     <= DEF_ODIV;
      pll_idsel  <= enc6(6'(DEF_IDIV));
      pll_fbdsel <= enc6(6'(DEF_FBDIV));
      pll_mdsel  <= enc7(7'(DEF_MDIV));
      for (int i = 0; i < NUM_OUT; i++)
        pll_odsel[i*7 +: 7] <= enc7(DEF_ODIV[i*7 +: 7]);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      retry_q   <= retry_d;
      err_cfg_q <= err_cfg_d;
      idiv_q    <= idiv_d;
      fbdiv_q   <= fbdiv_d;
      mdiv_q    <= mdiv_d;
      odiv_q    <= odiv_d;
      if (state_q == S_APPLY) begin
        pll_idsel  <= enc6(idiv_q);
        pll_fbdsel <= enc6(fbdiv_q);
        pll_mdsel  <= enc7(mdiv_q);
        for (int i = 0; i < NUM_OUT; i++)
          pll_odsel[i*7 +: 7] <= enc7(odiv_q[i*7 +: 7]);
      end
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed and randomized bench for pll_dyn_ctrl.
// Expected selects come from divider arithmetic on a bench-side shadow.
module tb_pll_dyn_ctrl;

  localparam int NO   = 2;
  localparam int TO   = 1000;
  localparam int HOLD = 32;
  localparam int FILT = 256;
  localparam int SYNC = 2;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic pll_lock = 1'b0;
  logic [5:0] cfg_idiv = 6'd1;
  logic [5:0] cfg_fbdiv = 6'd1;
  logic [6:0] cfg_mdiv = 7'd32;
  logic [NO*7-1:0] cfg_odiv = '0;
  logic cfg_ready, pll_reset, locked, busy, err_cfg, err_fail;
  logic [5:0] pll_idsel, pll_fbdsel;
  logic [6:0] pll_mdsel;
  logic [NO*7-1:0] pll_odsel;
  logic [NO-1:0] pll_enclk;

  int tests = 0;
  int fails = 0;
  int m_i = 1, m_f = 1, m_m = 32;
  int m_o[NO] = '{8, 8};

  always #5 clkin = ~clkin;

  pll_dyn_ctrl #(
    .NUM_OUT(NO),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clkin(clkin), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv),
    .cfg_mdiv(cfg_mdiv), .cfg_odiv(cfg_odiv),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_mdsel(pll_mdsel), .pll_odsel(pll_odsel),
    .pll_enclk(pll_enclk), .locked(locked), .busy(busy),
    .err_cfg(err_cfg), .err_fail(err_fail)
  );

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int e6(input int d);
    return (64 - d) % 64;
  endfunction

  function automatic int e7(input int d);
    return (128 - d) % 128;
  endfunction

  task automatic check_sels(input string tag);
    int eo;
    chk({tag, ".idsel"}, 32'(pll_idsel), 32'(e6(m_i)));
    chk({tag, ".fbdsel"}, 32'(pll_fbdsel), 32'(e6(m_f)));
    chk({tag, ".mdsel"}, 32'(pll_mdsel), 32'(e7(m_m)));
    eo = e7(m_o[1]) * 128 + e7(m_o[0]);
    chk({tag, ".odsel"}, 32'(pll_odsel), 32'(eo));
  endtask

  task automatic offer(input int i, input int f, input int m,
                       input int o0, input int o1, output bit legal);
    int n = 0;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    chk("offer.ready", 32'(cfg_ready), 32'd1);
    cfg_idiv  = 6'(i);
    cfg_fbdiv = 6'(f);
    cfg_mdiv  = 7'(m);
    cfg_odiv  = {7'(o1), 7'(o0)};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    legal = (i != 0) && (f != 0) && (m != 0) && (o0 != 0) && (o1 != 0);
    if (legal) begin
      m_i = i; m_f = f; m_m = m; m_o[0] = o0; m_o[1] = o1;
      pll_lock = 1'b0;
    end
  endtask

  task automatic relock(input bit glitch);
    int n = 0;
    while (!pll_reset && n < 50) begin tick(); n++; end
    chk("relock.rst_rise", 32'(pll_reset), 32'd1);
    chk("relock.busy_ready", 32'(cfg_ready), 32'd0);
    check_sels("relock");
    n = 0;
    while (pll_reset && n < 100) begin n++; tick(); end
    chk("relock.rst_len", 32'(n), 32'(HOLD));
    repeat (10) tick();
    pll_lock = 1'b1;
    if (glitch) begin
      repeat (100) tick();
      chk("glitch.early", 32'(locked), 32'd0);
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
    end
    n = 0;
    while (!locked && n < 400) begin tick(); n++; end
    chk("relock.latency", 32'(n), 32'(SYNC + FILT));
    chk("relock.enclk", 32'(pll_enclk), 32'(2'b11));
    chk("relock.busy", 32'(busy), 32'd0);
  endtask

  function automatic int rdiv(input int hi);
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(1, hi));
  endfunction

  initial begin
    bit lg;
    int n, rises;
    logic prev;

    repeat (5) tick();
    chk("rst.pll_reset", 32'(pll_reset), 32'd1);
    chk("rst.enclk", 32'(pll_enclk), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.ready", 32'(cfg_ready), 32'd0);
    chk("rst.err_cfg", 32'(err_cfg), 32'd0);
    chk("rst.err_fail", 32'(err_fail), 32'd0);
    check_sels("rst");
    chk("rst.mdsel96", 32'(pll_mdsel), 32'd96);

    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 500; k++) begin
      if (pll_reset) n++;
      tick();
    end
    chk("pwr.rst_len", 32'(n), 32'(HOLD));
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 400) begin tick(); n++; end
    chk("pwr.latency", 32'(n), 32'(SYNC + FILT));
    chk("pwr.ready", 32'(cfg_ready), 32'd1);
    chk("pwr.enclk", 32'(pll_enclk), 32'(2'b11));

    offer(1, 1, 40, 10, 8, lg);
    chk("recfg.enclk_fall", 32'(pll_enclk), 32'd0);
    chk("recfg.locked", 32'(locked), 32'd0);
    relock(1'b0);
    chk("recfg.mdsel88", 32'(pll_mdsel), 32'd88);
    chk("recfg.odsel118", 32'(pll_odsel[6:0]), 32'd118);

    offer(0, 1, 40, 10, 8, lg);
    chk("ill.err_cfg", 32'(err_cfg), 32'd1);
    tick();
    chk("ill.err_cfg_end", 32'(err_cfg), 32'd0);
    chk("ill.locked", 32'(locked), 32'd1);
    check_sels("ill");

    for (int k = 0; k < 6; k++) begin
      offer(rdiv(63), rdiv(63), rdiv(127), rdiv(127), rdiv(127), lg);
      if (lg) begin
        relock(1'b0);
      end else begin
        chk("rnd.err_cfg", 32'(err_cfg), 32'd1);
        tick();
        chk("rnd.err_cfg_end", 32'(err_cfg), 32'd0);
        chk("rnd.locked", 32'(locked), 32'd1);
        check_sels("rnd_ill");
      end
    end

    offer($urandom_range(1, 63), 2, $urandom_range(2, 127), 5, 7, lg);
    prev = pll_reset;
    rises = 1;
    rises = 0;
    n = 0;
    while (!err_fail && n < 5000) begin
      tick();
      n++;
      if (pll_reset && !prev && !err_fail) rises++;
      prev = pll_reset;
    end
    chk("nolock.pulses", 32'(rises), 32'd3);
    chk("nolock.err_fail", 32'(err_fail), 32'd1);
    chk("nolock.ready", 32'(cfg_ready), 32'd1);
    chk("nolock.busy", 32'(busy), 32'd0);
    check_sels("nolock");

    offer(3, 4, 20, 9, 11, lg);
    chk("fail.clear", 32'(err_fail), 32'd0);
    relock(1'b1);

    pll_lock = 1'b0;
    n = 0;
`ifdef PLL_AUTO_RELOCK_EN
    while (!pll_reset && n < 10) begin tick(); n++; end
    chk("drop.relock_start", 32'(pll_reset), 32'd1);
    chk("drop.enclk", 32'(pll_enclk), 32'd0);
    relock(1'b0);
    chk("drop.no_fail", 32'(err_fail), 32'd0);
`else
    while (!err_fail && n < 10) begin tick(); n++; end
    chk("drop.err_fail", 32'(err_fail), 32'd1);
    chk("drop.locked", 32'(locked), 32'd0);
    chk("drop.enclk", 32'(pll_enclk), 32'd0);
    chk("drop.ready", 32'(cfg_ready), 32'd1);
`endif

    offer(7, 9, 50, 60, 70, lg);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    m_i = 1; m_f = 1; m_m = 32; m_o[0] = 8; m_o[1] = 8;
    check_sels("midrst");
    chk("midrst.busy", 32'(busy), 32'd1);
    chk("midrst.ready", 32'(cfg_ready), 32'd0);
    chk("midrst.pll_reset", 32'(pll_reset), 32'd1);
    chk("midrst.err_fail", 32'(err_fail), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Sequencer for the GW5A `PLL` primitive's dynamic-divider ports. Supersedes fixed-defparam PLL wrappers.
- Holds a runtime divider set (IDIV, FBDIV, MDIV, ODIV0..NUM_OUT-1) and drives the encoded `*SEL` ports and the PLL reset.
- Controls per-output `ENCLK` gating, waits for a filtered lock, and handles loss of lock.
- Runs on the board oscillator, which also feeds the PLL `CLKIN`; instantiated next to the PLL in each example top.

Parameters:
- NUM_OUT, 1, number of PLL outputs controlled (1..7).
- DEF_IDIV, 1, power-up input divider (1..64).
- DEF_FBDIV, 1, power-up feedback divider (1..64).
- DEF_MDIV, 32, power-up M divider (2..128).
- DEF_ODIV, {7{7'd8}}, power-up output dividers, 7 bits each, packed NUM_OUT*7 (1..128).
- RST_HOLD, 32, cycles `pll_reset` is held high per attempt.
- LOCK_FILT, 256, consecutive synced-lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 100000, cycles allowed in WAIT_LOCK before the attempt fails.
- MAX_RETRY, 3, failed attempts before FAIL.

Ports:
- clkin  in  1  free-running reference clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- cfg_valid  in  1  new divider set offered.
- cfg_ready  out  1  controller accepts a set this cycle.
- cfg_idiv  in  6  IDIV value.
- cfg_fbdiv  in  6  FBDIV value.
- cfg_mdiv  in  7  MDIV value.
- cfg_odiv  in  NUM_OUT*7  ODIV values; ch0 in the LSBs.
- pll_lock  in  1  raw PLL LOCK, asynchronous.
- pll_reset  out  1  to PLL RESET.
- pll_idsel  out  6  to IDSEL.
- pll_fbdsel  out  6  to FBDSEL.
- pll_mdsel  out  7  to MDSEL.
- pll_odsel  out  NUM_OUT*7  to ODSEL0..n.
- pll_enclk  out  NUM_OUT  to ENCLK0..n.
- locked  out  1  filtered lock; outputs enabled.
- busy  out  1  sequence in progress.
- err_cfg  out  1  one-cycle pulse: offered set illegal, rejected.
- err_fail  out  1  sticky; MAX_RETRY exhausted.

Behaviour:
- **Encoding (registered):**
  - 6-bit: sel = 64 - div.
  - 7-bit: sel = 128 - div.
  - Computed modulo width, so div = 64 gives 0 and div = 128 gives 0.
  - The `*SEL` outputs change only in APPLY.
- **Lock input:** `pll_lock` passes through a 2-flop synchroniser; all FSM decisions use the synced value.
- **Reset values:**
  - `pll_reset` = 1, `pll_enclk` = 0, `locked` = 0, `busy` = 1, `cfg_ready` = 0.
  - `err_cfg` = 0, `err_fail` = 0, retry count = 0.
  - Shadow register = DEF_*; `*SEL` = encoded DEF_*.
  - After `reset` falls, the FSM enters RST_HOLD.
- **FSM states and transitions:**
  - **RUN:** `cfg_ready` = 1, `locked` = 1, `busy` = 0, `pll_enclk` all 1.
    - Handshake: `cfg_valid` & `cfg_ready` accepts the set.
    - Legal set: capture into the shadow register; go to GATE.
    - Illegal set (any div 0, IDIV/FBDIV > 64): pulse `err_cfg`, stay in RUN, shadow unchanged.
    - Synced lock falls: handled per PLL_AUTO_RELOCK_EN.
  - **GATE:** `pll_enclk` = 0, `locked` = 0, `busy` = 1. Held 2 cycles, then APPLY.
  - **APPLY:** 1 cycle; load encoded `*SEL` from the shadow register; go to RST_HOLD.
  - **RST_HOLD:** `pll_reset` = 1 for RST_HOLD cycles, then deasserted on entry to WAIT_LOCK.
  - **WAIT_LOCK:** wait for synced lock high, then go to LOCK_FILT.
    - On LOCK_TIMEOUT: increment retry count. If count = MAX_RETRY go to FAIL, else go to RST_HOLD.
  - **LOCK_FILT:** count consecutive synced-lock-high cycles.
    - Lock low: counter clears, return to WAIT_LOCK; the timeout counter keeps running.
    - Count = LOCK_FILT: retry count clears, go to RUN; `locked` and `pll_enclk` rise together on entry.
  - **FAIL:**
    - Signals: `err_fail` = 1, `pll_reset` = 1, `pll_enclk` = 0, `busy` = 0, `cfg_ready` = 1.
    - A legal set clears `err_fail` and the retry count, then goes to GATE.
    - An illegal set pulses `err_cfg` and stays in FAIL.
- **Boundary conditions:**
  - `cfg_valid` while `busy`: ignored (`cfg_ready` = 0); the offerer holds it.
  - `reset` mid-sequence: immediate return to reset values, including DEF_* dividers; any pending set is discarded.
  - Lock fall and `cfg_valid` in the same RUN cycle: the config wins (GATE); the lock fall is not counted as a retry.
  - Counter widths are derived with $clog2. Counters saturate and do not wrap.

Optional Feature:
- Macro: PLL_AUTO_RELOCK_EN.
- Defined: a synced lock fall in RUN forces `pll_enclk` = 0 and `locked` = 0 the same cycle, then goes to RST_HOLD with the current `*SEL` values. This attempt counts toward MAX_RETRY.
- Undefined:
  - A lock fall in RUN drops `locked` and `pll_enclk` and moves to FAIL; `err_fail` is set.
  - Recovery needs a new set or `reset`.

Decomposition:
- Package `pll_dyn_pkg`:
  - FSM state enum.
  - Divider width constants: 6 and 7.
  - Functions `enc6` and `enc7`.
  - Legality check function.
- Sub-module `pll_lock_filter`: 2-flop synchroniser plus consecutive-high counter. Outputs: synced lock and filter-done.

Test Plan:
- Power-up: release `reset`; lock rises 500 cycles later → `*SEL` = {63, 63, 96, 120} (ch0), `pll_reset` high 32 cycles, `locked` = 1 exactly 256 cycles after synced lock.
- Reconfig: in RUN offer MDIV = 40, ODIV0 = 10 → `pll_enclk` falls next cycle, `pll_mdsel` = 88, `pll_odsel[6:0]` = 118, full reset/lock sequence, `locked` = 1.
- Illegal set: IDIV = 0 → `err_cfg` pulses 1 cycle, `*SEL` and `locked` unchanged.
- Lock glitch: lock high 100 cycles, low 1 cycle, high → filter restarts, `locked` only after 256 uninterrupted cycles.
- Never lock, LOCK_TIMEOUT = 1000 → exactly 3 RST_HOLD pulses, then `err_fail` = 1 and `cfg_ready` = 1; a legal set clears `err_fail`.
- Lock drop in RUN: with PLL_AUTO_RELOCK_EN → relock without `err_fail`; without the macro → FAIL, `err_fail` = 1.
